tc_pwl_calc: RTL and testbench

Parametrised piecewise-linear thermocouple linearizer. It converts an ADC code into temperature in fixed-point units using 2^SEG_BITS runtime-loadable segments, adds a signed cold-junction offset and saturates the result. It sits between the ADC sequencer and the output formatter, with valid/ready handshakes on both sides and a channel tag carried through. Replaces the fixed 4-segment type-K converter and allows per-thermocouple-type tables.

---
 rtl/tc_pwl_calc.sv | 156 +++++++++++++++
 tb/tb_tc_pwl_calc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tc_pwl_calc.sv
// Piecewise-linear thermocouple linearizer: runtime-loadable slope/intercept
// table indexed by the code MSBs, plus signed cold-junction offset and clamp.
module tc_pwl_calc #(
  parameter int CODE_W   = 10,
  parameter int SEG_BITS = 2,
  parameter int SLOPE_W  = 12,
  parameter int OUT_W    = 20,
  parameter int CJ_W     = 16,
  parameter int TAG_W    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [CODE_W-1:0]          i_code,
  input  logic signed [CJ_W-1:0]     i_cj,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUT_W-1:0]           o_temp,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_sat,
  input  logic                       i_cfg_we,
  input  logic                       i_cfg_sel,
  input  logic [SEG_BITS-1:0]        i_cfg_addr,
  input  logic [OUT_W-1:0]           i_cfg_data
);

  localparam int V_W    = CODE_W - SEG_BITS;
  localparam int NSEG   = 1 << SEG_BITS;
  localparam int PROD_W = SLOPE_W + V_W;
  localparam int SUM_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_OUT = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SUM, S_OUT} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       w_accept;
  logic                       w_done;

  logic [SLOPE_W-1:0]         r_slope [NSEG];
  logic [OUT_W-1:0]           r_icpt  [NSEG];

  logic [SEG_BITS-1:0]        r_seg_p0;
  logic [V_W-1:0]             r_v_p0;
  logic signed [CJ_W-1:0]     r_cj_p0;
  logic [TAG_W-1:0]           r_tag_p0;
  logic [SLOPE_W-1:0]         r_slope_p1;
  logic [OUT_W-1:0]           r_icpt_p1;
  logic [PROD_W-1:0]          r_prod_p2;
  logic signed [SUM_W-1:0]    w_sum;

  logic                       r_vld;
  logic [OUT_W-1:0]           r_temp;
  logic [TAG_W-1:0]           r_tag;
  logic                       r_sat;

  // Returns {sat, clamped value}; negative sums clamp to zero, overflow to all ones.
  function automatic logic [OUT_W:0] sat_out(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      return {1'b1, {OUT_W{1'b0}}};
    else if (s > MAX_OUT)
      return {1'b1, {OUT_W{1'b1}}};
    else
      return {1'b0, s[OUT_W-1:0]};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_LOAD;
      S_LOAD:  w_next = S_MUL;
      S_MUL:   w_next = S_SUM;
      S_SUM:   w_next = S_OUT;
      S_OUT:   if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (r_state == S_IDLE);
    w_accept = (r_state == S_IDLE) && i_valid;
    w_done   = (r_state == S_OUT) && i_ready;
  end

  // Table writes land on the edge, so a LOAD on the same edge sees the old entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NSEG; k++) begin
        r_slope[k] <= '0;
        r_icpt[k]  <= '0;
      end
    end else if (i_cfg_we) begin
      if (i_cfg_sel) r_icpt[i_cfg_addr]  <= i_cfg_data;
      else           r_slope[i_cfg_addr] <= i_cfg_data[SLOPE_W-1:0];
    end
  end

  // p0: request capture
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_seg_p0 <= i_code[CODE_W-1 -: SEG_BITS];
      r_v_p0   <= i_code[V_W-1:0];
      r_cj_p0  <= i_cj;
      r_tag_p0 <= i_tag;
    end
  end

  // p1: coefficient fetch
  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD) begin
      r_slope_p1 <= r_slope[r_seg_p0];
      r_icpt_p1  <= r_icpt[r_seg_p0];
    end
  end

  // p2: product
  always_ff @(posedge i_clk) begin
    if (r_state == S_MUL)
      r_prod_p2 <= PROD_W'(r_slope_p1) * PROD_W'(r_v_p0);
  end

  always_comb begin
    w_sum = $signed({{(SUM_W-OUT_W){1'b0}}, r_icpt_p1})
          + $signed({{(SUM_W-PROD_W){1'b0}}, r_prod_p2})
          + $signed({{(SUM_W-CJ_W){r_cj_p0[CJ_W-1]}}, r_cj_p0});
  end

  // Result register, held in OUT until the downstream handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_temp <= '0;
      r_tag  <= '0;
      r_sat  <= 1'b0;
    end else if (r_state == S_SUM) begin
      {r_sat, r_temp} <= sat_out(w_sum);
      r_tag           <= r_tag_p0;
      r_vld           <= 1'b1;
    end else if (w_done) begin
      r_vld <= 1'b0;
    end
  end

  assign o_valid = r_vld;
  assign o_temp  = r_temp;
  assign o_tag   = r_tag;
  assign o_sat   = r_sat;

endmodule

// File: tb/tb_tc_pwl_calc.sv
// Directed bench for tc_pwl_calc using a type-K table and hand-computed results.
module tb_tc_pwl_calc;

  logic               clk = 1'b0;
  logic               i_rst, i_valid, o_ready, o_valid, i_ready, o_sat;
  logic [9:0]         i_code;
  logic signed [15:0] i_cj;
  logic [1:0]         i_tag, o_tag;
  logic [19:0]        o_temp;
  logic               i_cfg_we, i_cfg_sel;
  logic [1:0]         i_cfg_addr;
  logic [19:0]        i_cfg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tc_pwl_calc #(
    .CODE_W(10), .SEG_BITS(2), .SLOPE_W(12), .OUT_W(20), .CJ_W(16), .TAG_W(2)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_code(i_code), .i_cj(i_cj), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_temp(o_temp), .o_tag(o_tag), .o_sat(o_sat),
    .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] addr, input logic [19:0] data);
    i_cfg_we = 1'b1; i_cfg_sel = sel; i_cfg_addr = addr; i_cfg_data = data;
    tick;
    i_cfg_we = 1'b0;
  endtask

  // Presents one request and waits (bounded) for o_valid; lat counts cycles after the accept edge.
  task automatic send(input logic [9:0] code, input logic signed [15:0] cj, input logic [1:0] tag,
                      output int lat);
    i_valid = 1'b1; i_code = code; i_cj = cj; i_tag = tag;
    tick;
    i_valid = 1'b0;
    lat = 1;
    tick;
    while (o_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic handshake;
    i_ready = 1'b1;
    tick;
  endtask

  task automatic load_typek;
    cfg_write(1'b0, 2'd0, 20'd132);
    cfg_write(1'b0, 2'd1, 20'd127);
    cfg_write(1'b0, 2'd2, 20'd132);
    cfg_write(1'b0, 2'd3, 20'd147);
    cfg_write(1'b1, 2'd0, 20'd0);
    cfg_write(1'b1, 2'd1, 20'd33536);
    cfg_write(1'b1, 2'd2, 20'd65924);
    cfg_write(1'b1, 2'd3, 20'd99678);
  endtask

  task automatic test_reset;
    int lat;
    i_rst = 1'b1;
    repeat (3) tick;
    i_rst = 1'b0;
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL reset_temp: got %0d want 0", o_temp); end
    n_cmp++; if (o_tag !== 2'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", o_tag); end
    n_cmp++; if (o_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", o_sat); end
    send(10'd511, 16'sd0, 2'd1, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL reset_empty_lat: got %0d want 3", lat); end
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL reset_empty_temp: got %0d want 0", o_temp); end
    handshake;
  endtask

  task automatic test_typek;
    int lat;
    send(10'd511, 16'sd0, 2'd2, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL typek_lat: got %0d want 3", lat); end
    n_cmp++; if (o_temp !== 20'd65921) begin n_bad++; $display("FAIL typek_temp: got %0d want 65921", o_temp); end
    n_cmp++; if (o_sat !== 1'b0) begin n_bad++; $display("FAIL typek_sat: got %b want 0", o_sat); end
    n_cmp++; if (o_tag !== 2'd2) begin n_bad++; $display("FAIL typek_tag: got %0d want 2", o_tag); end
    handshake;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL typek_hs_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL typek_hs_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_cj;
    int lat;
    send(10'd1023, -16'sd100, 2'd1, lat);
    n_cmp++; if (o_temp !== 20'd137063) begin n_bad++; $display("FAIL cj_neg100_temp: got %0d want 137063", o_temp); end
    n_cmp++; if (o_sat !== 1'b0) begin n_bad++; $display("FAIL cj_neg100_sat: got %b want 0", o_sat); end
    handshake;
    send(10'd0, 16'sd25, 2'd3, lat);
    n_cmp++; if (o_temp !== 20'd25) begin n_bad++; $display("FAIL cj_pos25_temp: got %0d want 25", o_temp); end
    n_cmp++; if (o_tag !== 2'd3) begin n_bad++; $display("FAIL cj_pos25_tag: got %0d want 3", o_tag); end
    handshake;
    send(10'd0, -16'sd5, 2'd0, lat);
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL cj_under_temp: got %0d want 0", o_temp); end
    n_cmp++; if (o_sat !== 1'b1) begin n_bad++; $display("FAIL cj_under_sat: got %b want 1", o_sat); end
    handshake;
  endtask

  task automatic test_sat_high;
    int lat;
    cfg_write(1'b1, 2'd3, 20'd1048000);
    send(10'd1023, 16'sd0, 2'd2, lat);
    n_cmp++; if (o_temp !== 20'd1048575) begin n_bad++; $display("FAIL sat_high_temp: got %0d want 1048575", o_temp); end
    n_cmp++; if (o_sat !== 1'b1) begin n_bad++; $display("FAIL sat_high_sat: got %b want 1", o_sat); end
    handshake;
    cfg_write(1'b1, 2'd3, 20'd99678);
  endtask

  task automatic test_backpressure;
    int lat;
    logic seen;
    i_ready = 1'b0;
    send(10'd511, 16'sd0, 2'd1, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL bp_lat: got %0d want 3", lat); end
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin i_valid = 1'b1; i_code = 10'd1023; i_cj = 16'sd7; i_tag = 2'd3; end
      if (i == 8) i_valid = 1'b0;
      n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, o_valid); end
      n_cmp++; if (o_temp !== 20'd65921) begin n_bad++; $display("FAIL bp_temp[%0d]: got %0d want 65921", i, o_temp); end
      n_cmp++; if (o_tag !== 2'd1) begin n_bad++; $display("FAIL bp_tag[%0d]: got %0d want 1", i, o_tag); end
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, o_ready); end
      tick;
    end
    handshake;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
    seen = 1'b0;
    repeat (6) begin tick; if (o_valid === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_stale_request: got %b want 0", seen); end
  endtask

  task automatic test_cfg_race;
    int lat;
    i_valid = 1'b1; i_code = 10'd511; i_cj = 16'sd0; i_tag = 2'd3;
    tick;
    i_valid = 1'b0;
    i_cfg_we = 1'b1; i_cfg_sel = 1'b1; i_cfg_addr = 2'd1; i_cfg_data = 20'd500;
    tick;
    i_cfg_we = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin tick; lat++; end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL race_lat: got %0d want 3", lat); end
    n_cmp++; if (o_temp !== 20'd65921) begin n_bad++; $display("FAIL race_old_temp: got %0d want 65921", o_temp); end
    handshake;
    send(10'd511, 16'sd0, 2'd2, lat);
    n_cmp++; if (o_temp !== 20'd32885) begin n_bad++; $display("FAIL race_new_temp: got %0d want 32885", o_temp); end
    handshake;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic seen;
    i_valid = 1'b1; i_code = 10'd1023; i_cj = 16'sd0; i_tag = 2'd3;
    tick;
    i_valid = 1'b0;
    tick;
    i_rst = 1'b1;
    tick;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid_in_rst: got %b want 0", o_valid); end
    tick;
    i_rst = 1'b0;
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL rstmid_temp: got %0d want 0", o_temp); end
    n_cmp++; if (o_tag !== 2'd0) begin n_bad++; $display("FAIL rstmid_tag: got %0d want 0", o_tag); end
    n_cmp++; if (o_sat !== 1'b0) begin n_bad++; $display("FAIL rstmid_sat: got %b want 0", o_sat); end
    seen = 1'b0;
    repeat (5) begin tick; if (o_valid === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_result: got %b want 0", seen); end
    send(10'd300, 16'sd0, 2'd1, lat);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rstmid_code300_lat: got %0d want 3", lat); end
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL rstmid_code300_temp: got %0d want 0", o_temp); end
    handshake;
    send(10'd1023, 16'sd0, 2'd1, lat);
    n_cmp++; if (o_temp !== 20'd0) begin n_bad++; $display("FAIL rstmid_code1023_temp: got %0d want 0", o_temp); end
    handshake;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_code = '0; i_cj = '0; i_tag = '0;
    i_cfg_we = 1'b0; i_cfg_sel = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    test_reset;
    load_typek;
    test_typek;
    test_cj;
    test_sat_high;
    test_backpressure;
    test_cfg_race;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
